// File: rtl/ev_pop_streamer.sv
// Host-side loader for the evolutionary-algorithm core: buffers the self-energy,
// interaction and population tables, streams them on start, then captures the result.
module ev_pop_streamer #(
  parameter int INT8_LENGTH       = 8,
  parameter int ENERGY_LENGTH     = 4,
  parameter int PARTICLE_LENGTH   = 2,
  parameter int LATTICE_LENGTH    = 11,
  parameter int INDIVIDUAL_LENGTH = PARTICLE_LENGTH * LATTICE_LENGTH,
  parameter int IND_FIT_LENGTH    = 10,
  parameter int NUM_PARTICLE_TYPE = 3,
  parameter int POP_SIZE          = 40,
  parameter int TIMEOUT_W         = 16
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   cfg_we,
  input  logic [1:0]                                             cfg_sel,
  input  logic [5:0]                                             cfg_addr,
  input  logic [INT8_LENGTH+IND_FIT_LENGTH+INDIVIDUAL_LENGTH-1:0] cfg_wdata,
  input  logic                                                   start,
  output logic                                                   busy,
  output logic                                                   done,
  output logic                                                   timeout,
  output logic [ENERGY_LENGTH-1:0]                               self_energy_o,
  output logic [ENERGY_LENGTH-1:0]                               interact_energy_o,
  output logic [INT8_LENGTH-1:0]                                 mutate_rate_o,
  output logic [INDIVIDUAL_LENGTH-1:0]                           ind_state_o,
  output logic [IND_FIT_LENGTH-1:0]                              ind_fit_o,
  output logic                                                   in_valid_self_o,
  output logic                                                   in_valid_interact_o,
  output logic                                                   in_valid_ind_o,
  input  logic                                                   res_valid_i,
  input  logic [IND_FIT_LENGTH-1:0]                              min_fit_i,
  input  logic [INDIVIDUAL_LENGTH-1:0]                           best_state_i,
  input  logic [INT8_LENGTH-1:0]                                 best_mut_i,
  output logic [IND_FIT_LENGTH-1:0]                              res_fit_o,
  output logic [INDIVIDUAL_LENGTH-1:0]                           res_state_o,
  output logic [INT8_LENGTH-1:0]                                 res_mut_o
);
  localparam int NUM_INTERACT = NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE;
  localparam int CFG_W        = INT8_LENGTH + IND_FIT_LENGTH + INDIVIDUAL_LENGTH;
  localparam logic [5:0] SELF_LAST  = 6'(NUM_PARTICLE_TYPE - 1);
  localparam logic [5:0] INTER_LAST = 6'(NUM_INTERACT - 1);
  localparam logic [5:0] POP_LAST   = 6'(POP_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELF, S_GAP1, S_INTER, S_GAP2, S_POP, S_WAIT, S_FIN
  } state_t;

  state_t                 state_reg;
  logic [5:0]             idx_reg;
  logic [TIMEOUT_W-1:0]   wait_cnt_reg;
  logic [TIMEOUT_W-1:0]   wait_cnt_next;

  logic [ENERGY_LENGTH-1:0] self_tab  [NUM_PARTICLE_TYPE];
  logic [ENERGY_LENGTH-1:0] inter_tab [NUM_INTERACT];
  logic [CFG_W-1:0]         pop_tab   [POP_SIZE];

  logic [ENERGY_LENGTH-1:0] self_rd;
  logic [ENERGY_LENGTH-1:0] inter_rd;
  logic [CFG_W-1:0]         pop_rd;
  logic                     cfg_ok;

  assign cfg_ok        = cfg_we && (state_reg == S_IDLE);
  assign wait_cnt_next = wait_cnt_reg + 1'b1;

  // Out-of-range addresses match no entry, so they fall through untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PARTICLE_TYPE; i++) self_tab[i] <= '0;
    end else if (cfg_ok && cfg_sel == 2'd0) begin
      for (int i = 0; i < NUM_PARTICLE_TYPE; i++)
        if (cfg_addr == 6'(i)) self_tab[i] <= cfg_wdata[ENERGY_LENGTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_INTERACT; i++) inter_tab[i] <= '0;
    end else if (cfg_ok && cfg_sel == 2'd1) begin
      for (int i = 0; i < NUM_INTERACT; i++)
        if (cfg_addr == 6'(i)) inter_tab[i] <= cfg_wdata[ENERGY_LENGTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < POP_SIZE; i++) pop_tab[i] <= '0;
    end else if (cfg_ok && cfg_sel == 2'd2) begin
      for (int i = 0; i < POP_SIZE; i++)
        if (cfg_addr == 6'(i)) pop_tab[i] <= cfg_wdata;
    end
  end

  always_comb begin
    self_rd  = '0;
    inter_rd = '0;
    pop_rd   = '0;
    for (int i = 0; i < NUM_PARTICLE_TYPE; i++)
      if (idx_reg == 6'(i)) self_rd = self_tab[i];
    for (int i = 0; i < NUM_INTERACT; i++)
      if (idx_reg == 6'(i)) inter_rd = inter_tab[i];
    for (int i = 0; i < POP_SIZE; i++)
      if (idx_reg == 6'(i)) pop_rd = pop_tab[i];
  end

  // Outputs are registered from the current phase, so each phase appears one cycle after entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg           <= S_IDLE;
      idx_reg             <= '0;
      wait_cnt_reg        <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      timeout             <= 1'b0;
      self_energy_o       <= '0;
      interact_energy_o   <= '0;
      mutate_rate_o       <= '0;
      ind_state_o         <= '0;
      ind_fit_o           <= '0;
      in_valid_self_o     <= 1'b0;
      in_valid_interact_o <= 1'b0;
      in_valid_ind_o      <= 1'b0;
      res_fit_o           <= '0;
      res_state_o         <= '0;
      res_mut_o           <= '0;
    end else begin
      done                <= 1'b0;
      self_energy_o       <= '0;
      interact_energy_o   <= '0;
      mutate_rate_o       <= '0;
      ind_state_o         <= '0;
      ind_fit_o           <= '0;
      in_valid_self_o     <= 1'b0;
      in_valid_interact_o <= 1'b0;
      in_valid_ind_o      <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_SELF;
            idx_reg   <= '0;
            timeout   <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_SELF: begin
          in_valid_self_o <= 1'b1;
          self_energy_o   <= self_rd;
          if (idx_reg == SELF_LAST) begin
            state_reg <= S_GAP1;
            idx_reg   <= '0;
          end else begin
            idx_reg <= idx_reg + 6'd1;
          end
        end
        S_GAP1: begin
          state_reg <= S_INTER;
          idx_reg   <= '0;
        end
        S_INTER: begin
          in_valid_interact_o <= 1'b1;
          interact_energy_o   <= inter_rd;
          if (idx_reg == INTER_LAST) begin
            state_reg <= S_GAP2;
            idx_reg   <= '0;
          end else begin
            idx_reg <= idx_reg + 6'd1;
          end
        end
        S_GAP2: begin
          state_reg <= S_POP;
          idx_reg   <= '0;
        end
        S_POP: begin
          in_valid_ind_o <= 1'b1;
          mutate_rate_o  <= pop_rd[INDIVIDUAL_LENGTH+IND_FIT_LENGTH +: INT8_LENGTH];
          ind_fit_o      <= pop_rd[INDIVIDUAL_LENGTH +: IND_FIT_LENGTH];
          ind_state_o    <= pop_rd[INDIVIDUAL_LENGTH-1:0];
          if (idx_reg == POP_LAST) begin
            state_reg    <= S_WAIT;
            idx_reg      <= '0;
            wait_cnt_reg <= '0;
          end else begin
            idx_reg <= idx_reg + 6'd1;
          end
        end
        S_WAIT: begin
          // A result arriving on the saturating cycle still counts as on time.
          if (res_valid_i) begin
            res_fit_o   <= min_fit_i;
            res_state_o <= best_state_i;
            res_mut_o   <= best_mut_i;
            state_reg   <= S_FIN;
            done        <= 1'b1;
            busy        <= 1'b0;
          end else begin
            wait_cnt_reg <= wait_cnt_next;
            if (&wait_cnt_next) begin
              timeout   <= 1'b1;
              state_reg <= S_FIN;
              done      <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        S_FIN: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ev_pop_streamer.sv
// Randomized bench for ev_pop_streamer: a time-offset reference model of the
// load stream is compared against the DUT every cycle, plus hand-computed pins.
module tb_ev_pop_streamer;
  localparam int EL = 4, ML = 8, FL = 10, SL = 22, DW = 40;
  localparam int NP = 3, NI = 9, PS = 40, TW = 5;
  localparam int POP_END = NP + NI + 2 + PS;   // last stream cycle after start (54)
  localparam int TO_CYC  = (1 << TW) - 1;      // WAIT cycles until the counter saturates

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_we = 1'b0;
  logic [1:0] cfg_sel = 2'd3;
  logic [5:0] cfg_addr = '0;
  logic [DW-1:0] cfg_wdata = '0;
  logic start = 1'b0;
  logic res_valid_i = 1'b0;
  logic [FL-1:0] min_fit_i = '0;
  logic [SL-1:0] best_state_i = '0;
  logic [ML-1:0] best_mut_i = '0;
  logic busy, done, timeout;
  logic [EL-1:0] self_energy_o, interact_energy_o;
  logic [ML-1:0] mutate_rate_o;
  logic [SL-1:0] ind_state_o;
  logic [FL-1:0] ind_fit_o;
  logic in_valid_self_o, in_valid_interact_o, in_valid_ind_o;
  logic [FL-1:0] res_fit_o;
  logic [SL-1:0] res_state_o;
  logic [ML-1:0] res_mut_o;

  int n_checks = 0;
  int n_fail = 0;

  ev_pop_streamer #(.TIMEOUT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .busy(busy), .done(done), .timeout(timeout),
    .self_energy_o(self_energy_o), .interact_energy_o(interact_energy_o),
    .mutate_rate_o(mutate_rate_o), .ind_state_o(ind_state_o), .ind_fit_o(ind_fit_o),
    .in_valid_self_o(in_valid_self_o), .in_valid_interact_o(in_valid_interact_o),
    .in_valid_ind_o(in_valid_ind_o), .res_valid_i(res_valid_i), .min_fit_i(min_fit_i),
    .best_state_i(best_state_i), .best_mut_i(best_mut_i), .res_fit_o(res_fit_o),
    .res_state_o(res_state_o), .res_mut_o(res_mut_o)
  );

  initial forever #5 clk = ~clk;

  // Reference model: tables plus "cycles since start"; outputs follow from that offset.
  logic [EL-1:0] m_self [NP];
  logic [EL-1:0] m_inter [NI];
  logic [DW-1:0] m_pop [PS];
  bit m_active = 1'b0, m_fin = 1'b0;
  int m_t = 0;
  logic e_vs = 1'b0, e_vi = 1'b0, e_vp = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_to = 1'b0;
  logic [EL-1:0] e_self = '0, e_inter = '0;
  logic [ML-1:0] e_mut = '0, e_rmut = '0;
  logic [FL-1:0] e_fit = '0, e_rfit = '0;
  logic [SL-1:0] e_state = '0, e_rstate = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_self[i] = '0;
    for (int i = 0; i < NI; i++) m_inter[i] = '0;
    for (int i = 0; i < PS; i++) m_pop[i] = '0;
    m_active = 1'b0; m_fin = 1'b0; m_t = 0;
    {e_vs, e_vi, e_vp, e_busy, e_done, e_to} = '0;
    e_self = '0; e_inter = '0; e_mut = '0; e_fit = '0; e_state = '0;
    e_rfit = '0; e_rstate = '0; e_rmut = '0;
  endtask

  task automatic model_edge();
    bit idle;
    int a, j;
    idle = !m_active && !m_fin;
    if (m_fin) begin m_fin = 1'b0; e_done = 1'b0; end
    a = int'(cfg_addr);
    if (cfg_we && idle) begin
      if (cfg_sel == 2'd0 && a < NP) m_self[a] = cfg_wdata[EL-1:0];
      else if (cfg_sel == 2'd1 && a < NI) m_inter[a] = cfg_wdata[EL-1:0];
      else if (cfg_sel == 2'd2 && a < PS) m_pop[a] = cfg_wdata;
    end
    {e_vs, e_vi, e_vp} = '0;
    e_self = '0; e_inter = '0; e_mut = '0; e_fit = '0; e_state = '0;
    if (m_active) begin
      m_t++;
      if (m_t <= NP) begin
        e_vs = 1'b1; e_self = m_self[m_t-1];
      end else if (m_t >= NP + 2 && m_t <= NP + 1 + NI) begin
        e_vi = 1'b1; e_inter = m_inter[m_t-NP-2];
      end else if (m_t >= NP + NI + 3 && m_t <= POP_END) begin
        e_vp = 1'b1;
        e_mut = m_pop[m_t-NP-NI-3][DW-1:SL+FL];
        e_fit = m_pop[m_t-NP-NI-3][SL+FL-1:SL];
        e_state = m_pop[m_t-NP-NI-3][SL-1:0];
      end else if (m_t > POP_END) begin
        j = m_t - POP_END;
        if (res_valid_i) begin
          e_rfit = min_fit_i; e_rstate = best_state_i; e_rmut = best_mut_i;
          m_active = 1'b0; m_fin = 1'b1; e_done = 1'b1; e_busy = 1'b0;
        end else if (j == TO_CYC) begin
          e_to = 1'b1;
          m_active = 1'b0; m_fin = 1'b1; e_done = 1'b1; e_busy = 1'b0;
        end
      end
    end else if (idle && start) begin
      m_active = 1'b1; m_t = 0; e_to = 1'b0; e_busy = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_edge();
  end

  initial forever begin
    @(negedge clk);
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("timeout", 64'(timeout), 64'(e_to));
    chk("v_self", 64'(in_valid_self_o), 64'(e_vs));
    chk("v_inter", 64'(in_valid_interact_o), 64'(e_vi));
    chk("v_ind", 64'(in_valid_ind_o), 64'(e_vp));
    chk("self_e", 64'(self_energy_o), 64'(e_self));
    chk("inter_e", 64'(interact_energy_o), 64'(e_inter));
    chk("mut", 64'(mutate_rate_o), 64'(e_mut));
    chk("fit", 64'(ind_fit_o), 64'(e_fit));
    chk("state", 64'(ind_state_o), 64'(e_state));
    chk("res_fit", 64'(res_fit_o), 64'(e_rfit));
    chk("res_state", 64'(res_state_o), 64'(e_rstate));
    chk("res_mut", 64'(res_mut_o), 64'(e_rmut));
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] sel, input int addr, input logic [DW-1:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 6'(addr); cfg_wdata = d;
    step();
    cfg_we = 1'b0; cfg_sel = 2'd3;
  endtask

  function automatic logic [DW-1:0] pent(input int k);
    return {8'(k), 10'(k + 100), 22'(k)};
  endfunction

  // mode: 0 plain, 1 directed load pins, 2 timeout pins, 3 post-reset zero pins
  task automatic run(input int res_at, input bit noise, input int mode, output int done_c);
    done_c = -1;
    start = 1'b1;
    if (noise) begin
      cfg_we = 1'b1; cfg_sel = 2'd0; cfg_addr = 6'($urandom_range(0, 2)); cfg_wdata = 40'($urandom);
    end
    step();
    start = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd3;
    if (mode == 1) begin
      chk("busy_c0", 64'(busy), 64'(1));
      chk("vself_c0", 64'(in_valid_self_o), 64'(0));
    end
    for (int c = 1; c <= POP_END + 60 && done_c < 0; c++) begin
      if (c == 20) begin
        start = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd2; cfg_addr = 6'd0; cfg_wdata = pent(77);
      end else if (noise && c <= POP_END && $urandom_range(0, 7) == 0) begin
        start = 1'b1; cfg_we = 1'b1; cfg_sel = 2'($urandom); cfg_addr = 6'($urandom);
        cfg_wdata = 40'({$urandom, $urandom});
      end
      if ((noise && c <= POP_END && $urandom_range(0, 7) == 0) || c == POP_END + res_at) begin
        res_valid_i = 1'b1; min_fit_i = 10'($urandom); best_state_i = 22'($urandom);
        best_mut_i = 8'($urandom);
        if (mode == 1) begin min_fit_i = 10'd37; best_mut_i = 8'd5; end
      end
      step();
      start = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd3; res_valid_i = 1'b0;
      if (done) done_c = c;
      if (mode == 1) begin
        if (c == 1) chk("pin_self0", 64'(self_energy_o), 64'(1));
        if (c == 2) chk("pin_self1", 64'(self_energy_o), 64'(2));
        if (c == 3) chk("pin_self2", 64'(self_energy_o), 64'(3));
        if (c == 4) chk("pin_gap1", 64'({in_valid_self_o, in_valid_interact_o, in_valid_ind_o}), 64'(0));
        if (c == 5) chk("pin_int0", 64'(interact_energy_o), 64'(10));
        if (c == 6) chk("pin_int1", 64'(interact_energy_o), 64'(4));
        if (c == 14) chk("pin_gap2", 64'({in_valid_self_o, in_valid_interact_o, in_valid_ind_o}), 64'(0));
        if (c == 15) chk("pin_pop0", 64'({mutate_rate_o, ind_fit_o}), 64'({8'd0, 10'd100}));
        if (c == POP_END) chk("pin_pop39", 64'({mutate_rate_o, ind_fit_o}), 64'({8'd39, 10'd139}));
        if (c == POP_END + 1) chk("pin_vind_end", 64'(in_valid_ind_o), 64'(0));
      end else if (mode == 2) begin
        if (c == 15) chk("pin_pop0_kept", 64'(ind_fit_o), 64'(100));
      end else if (mode == 3) begin
        if (c == 1) chk("pin_z_self", 64'({in_valid_self_o, self_energy_o}), 64'({1'b1, 4'd0}));
        if (c == 15) chk("pin_z_pop", 64'({in_valid_ind_o, ind_fit_o}), 64'({1'b1, 10'd0}));
      end
    end
    chk("done_seen", 64'(done_c >= 0), 64'(1));
  endtask

  initial begin
    int dc;
    int ilist [NI] = '{10, 4, 1, 4, 10, 5, 1, 5, 10};
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_timeout", 64'(timeout), 64'(0));
    chk("rst_res_fit", 64'(res_fit_o), 64'(0));

    for (int k = 0; k < NP; k++) wr(2'd0, k, 40'(k + 1));
    for (int k = 0; k < NI; k++) wr(2'd1, k, 40'(ilist[k]));
    for (int k = 0; k < PS; k++) wr(2'd2, k, pent(k));
    wr(2'd2, 45, 40'hFF_FFFF_FFFF);
    wr(2'd0, 3, 40'd9);
    wr(2'd1, 9, 40'd7);
    res_valid_i = 1'b1; min_fit_i = 10'd999; best_mut_i = 8'd77; best_state_i = 22'd1234;
    step();
    res_valid_i = 1'b0;
    step();
    chk("idle_res_fit", 64'(res_fit_o), 64'(0));
    chk("idle_res_mut", 64'(res_mut_o), 64'(0));

    run(20, 1'b0, 1, dc);
    chk("res_done_cycle", 64'(dc), 64'(POP_END + 20));
    chk("res_fit37", 64'(res_fit_o), 64'(37));
    chk("res_mut5", 64'(res_mut_o), 64'(5));
    chk("res_no_to", 64'(timeout), 64'(0));
    step();
    chk("done_once", 64'(done), 64'(0));

    run(1000, 1'b0, 2, dc);
    chk("to_done_cycle", 64'(dc), 64'(POP_END + TO_CYC));
    chk("to_flag", 64'(timeout), 64'(1));
    chk("to_res_fit_hold", 64'(res_fit_o), 64'(37));
    chk("to_res_mut_hold", 64'(res_mut_o), 64'(5));
    step();

    run(TO_CYC, 1'b0, 0, dc);
    chk("tie_done_cycle", 64'(dc), 64'(POP_END + TO_CYC));
    chk("tie_no_to", 64'(timeout), 64'(0));
    chk("tie_res_fit", 64'(res_fit_o), 64'(min_fit_i));
    step();

    for (int r = 0; r < 6; r++) begin
      repeat (6) wr(2'($urandom_range(0, 3)), int'($urandom_range(0, 47)), 40'({$urandom, $urandom}));
      run(int'($urandom_range(1, 40)), 1'b1, 0, dc);
      step();
    end

    start = 1'b1;
    step();
    start = 1'b0;
    repeat (23) step();
    @(posedge clk);
    #1;
    chk("pre_rst_vind", 64'(in_valid_ind_o), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_vind", 64'(in_valid_ind_o), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    step();
    step();
    rst_n = 1'b1;
    step();

    run(5, 1'b0, 3, dc);
    chk("zero_done_cycle", 64'(dc), 64'(POP_END + 5));
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
